// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one memory port.
// Data requests have strict priority; a wait counter bounds each memory access.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_valid,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,

  output logic                stallF,
  output logic                stallM,
  output logic                err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  // Last wait cycle: the counter would reach TIMEOUT on this cycle's increment.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic                mem_req_q,    mem_req_d;
  logic                mem_wr_q,     mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q,  mem_wstrb_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                inst_valid_q, inst_valid_d;
  logic                data_valid_q, data_valid_d;
  logic                err_q,        err_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d     = DATA;
          cnt_d       = '0;
          mem_wr_d    = data_wr;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          mem_wstrb_d = data_wstrb;
        end else if (inst_req) begin
          state_d     = INST;
          cnt_d       = '0;
          mem_wr_d    = 1'b0;
          mem_addr_d  = inst_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end
      end

      INST, DATA: begin
        // An ack on the final wait cycle wins over the timeout.
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          err_d   = ~mem_ack;
          if (state_q == DATA) begin
            data_valid_d = 1'b1;
            data_rdata_d = (mem_ack && !mem_wr_q) ? mem_rdata : '0;
          end else begin
            inst_valid_d = 1'b1;
            inst_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    mem_req_d = (state_d == INST) || (state_d == DATA);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign inst_valid = inst_valid_q;
  assign data_valid = data_valid_q;
  assign err        = err_q;

  assign stallF = inst_req & ~inst_valid_q;
  assign stallM = data_req & ~data_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=4; cycle 0 is the cycle a request is first presented in IDLE.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stallF;
  logic        stallM;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_rdata(inst_rdata),
    .inst_valid(inst_valid),
    .data_req  (data_req),
    .data_wr   (data_wr),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_wstrb(data_wstrb),
    .data_rdata(data_rdata),
    .data_valid(data_valid),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stallF    (stallF),
    .stallM    (stallM),
    .err       (err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_wr, inst_valid, data_valid, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_wr, inst_valid, data_valid, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin
      failures++;
      $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_wdata, mem_wstrb});
    end
    checks++;
    if ({inst_rdata, data_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", {inst_rdata, data_rdata});
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_fetch();
    logic exp_req;
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0100;
    for (int c = 0; c < 7; c++) begin
      mem_ack   = (c >= 3);
      mem_rdata = (c == 3) ? 32'hDEAD_BEEF : (32'hBAD0_0000 | 32'(c));
      if (c >= 5) inst_req = 1'b0;
      @(negedge clk);
      exp_req = (c >= 1) && (c <= 3);
      checks++;
      if (mem_req !== exp_req) begin
        failures++;
        $display("FAIL fetch_mem_req c=%0d got=%b exp=%b", c, mem_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if ({mem_addr, mem_wr, mem_wstrb} !== {32'h0000_0100, 1'b0, 4'h0}) begin
          failures++;
          $display("FAIL fetch_mem_bus c=%0d got=%h/%b/%h exp=00000100/0/0", c, mem_addr, mem_wr, mem_wstrb);
        end
      end
      checks++;
      if (inst_valid !== (c == 4) || data_valid !== 1'b0) begin
        failures++;
        $display("FAIL fetch_valid c=%0d got=%b%b exp=%b0", c, inst_valid, data_valid, (c == 4));
      end
      checks++;
      if (stallF !== (c <= 3)) begin
        failures++;
        $display("FAIL fetch_stallF c=%0d got=%b exp=%b", c, stallF, (c <= 3));
      end
      if (c >= 4) begin
        checks++;
        if (inst_rdata !== 32'hDEAD_BEEF) begin
          failures++;
          $display("FAIL fetch_rdata c=%0d got=%h exp=deadbeef", c, inst_rdata);
        end
      end
      next_cycle();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_priority();
    logic exp_req;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0200;
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0300;
    for (int c = 0; c < 7; c++) begin
      mem_ack   = (c == 1) || (c == 4);
      mem_rdata = (c == 1) ? 32'hAAAA_5555 : (c == 4) ? 32'h0F0F_1234 : 32'hBAD0_0000;
      if (c >= 3) data_req = 1'b0;
      if (c >= 6) inst_req = 1'b0;
      @(negedge clk);
      exp_req = (c == 1) || (c == 4);
      checks++;
      if (mem_req !== exp_req) begin
        failures++;
        $display("FAIL prio_mem_req c=%0d got=%b exp=%b", c, mem_req, exp_req);
      end
      if (c == 1 || c == 4) begin
        checks++;
        if (mem_addr !== ((c == 1) ? 32'h0000_0200 : 32'h0000_0300)) begin
          failures++;
          $display("FAIL prio_mem_addr c=%0d got=%h", c, mem_addr);
        end
      end
      checks++;
      if (data_valid !== (c == 2) || inst_valid !== (c == 5)) begin
        failures++;
        $display("FAIL prio_valid c=%0d got d=%b i=%b exp d=%b i=%b", c, data_valid, inst_valid, (c == 2), (c == 5));
      end
      checks++;
      if (stallM !== (c <= 1) || stallF !== (c <= 4)) begin
        failures++;
        $display("FAIL prio_stall c=%0d got M=%b F=%b exp M=%b F=%b", c, stallM, stallF, (c <= 1), (c <= 4));
      end
      if (c == 2) begin
        checks++;
        if (data_rdata !== 32'hAAAA_5555) begin
          failures++;
          $display("FAIL prio_data_rdata got=%h exp=aaaa5555", data_rdata);
        end
      end
      if (c == 5) begin
        checks++;
        if (inst_rdata !== 32'h0F0F_1234) begin
          failures++;
          $display("FAIL prio_inst_rdata got=%h exp=0f0f1234", inst_rdata);
        end
      end
      next_cycle();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    logic exp_req;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0500;
    mem_ack   = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 8; c++) begin
      if (c >= 6) data_req = 1'b0;
      @(negedge clk);
      exp_req = (c >= 1) && (c <= 4);
      checks++;
      if (mem_req !== exp_req) begin
        failures++;
        $display("FAIL tmo_mem_req c=%0d got=%b exp=%b", c, mem_req, exp_req);
      end
      checks++;
      if (data_valid !== (c == 5) || err !== (c == 5) || inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL tmo_valid_err c=%0d got v=%b e=%b iv=%b exp v=%b e=%b iv=0", c, data_valid, err, inst_valid, (c == 5), (c == 5));
      end
      if (c == 5) begin
        checks++;
        if (data_rdata !== 32'h0) begin
          failures++;
          $display("FAIL tmo_rdata got=%h exp=00000000", data_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_ack_at_limit();
    logic exp_req;
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0600;
    for (int c = 0; c < 7; c++) begin
      mem_ack   = (c == 4);
      mem_rdata = (c == 4) ? 32'h600D_F00D : 32'hBAD0_0001;
      if (c >= 6) inst_req = 1'b0;
      @(negedge clk);
      exp_req = (c >= 1) && (c <= 4);
      checks++;
      if (mem_req !== exp_req) begin
        failures++;
        $display("FAIL limit_mem_req c=%0d got=%b exp=%b", c, mem_req, exp_req);
      end
      checks++;
      if (inst_valid !== (c == 5) || err !== 1'b0) begin
        failures++;
        $display("FAIL limit_valid_err c=%0d got v=%b e=%b exp v=%b e=0", c, inst_valid, err, (c == 5));
      end
      if (c == 5) begin
        checks++;
        if (inst_rdata !== 32'h600D_F00D) begin
          failures++;
          $display("FAIL limit_rdata got=%h exp=600df00d", inst_rdata);
        end
      end
      next_cycle();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_store();
    logic exp_req;
    data_req   = 1'b1;
    data_wr    = 1'b1;
    data_addr  = 32'h0000_0400;
    data_wdata = 32'h1234_5678;
    data_wstrb = 4'h3;
    for (int c = 0; c < 5; c++) begin
      mem_ack   = (c == 2);
      mem_rdata = 32'hFFFF_FFFF;
      if (c >= 4) data_req = 1'b0;
      @(negedge clk);
      exp_req = (c >= 1) && (c <= 2);
      checks++;
      if (mem_req !== exp_req) begin
        failures++;
        $display("FAIL store_mem_req c=%0d got=%b exp=%b", c, mem_req, exp_req);
      end
      if (exp_req) begin
        checks++;
        if ({mem_wr, mem_wstrb, mem_wdata, mem_addr} !== {1'b1, 4'h3, 32'h1234_5678, 32'h0000_0400}) begin
          failures++;
          $display("FAIL store_mem_bus c=%0d got=%b/%h/%h/%h exp=1/3/12345678/00000400", c, mem_wr, mem_wstrb, mem_wdata, mem_addr);
        end
      end
      checks++;
      if (data_valid !== (c == 3) || err !== 1'b0) begin
        failures++;
        $display("FAIL store_valid c=%0d got v=%b e=%b exp v=%b e=0", c, data_valid, err, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (data_rdata !== 32'h0) begin
          failures++;
          $display("FAIL store_rdata got=%h exp=00000000", data_rdata);
        end
      end
      next_cycle();
    end
    mem_ack    = 1'b0;
    data_wr    = 1'b0;
    data_wstrb = 4'h0;
    data_wdata = 32'h0;
  endtask

  task automatic test_reset_midflight();
    logic exp_req;
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h0000_0700;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) begin
        rst      = 1'b0;
        data_req = 1'b0;
      end
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0800;
      end
      if (c >= 8) inst_req = 1'b0;
      mem_ack   = (c == 6);
      mem_rdata = (c == 6) ? 32'h1357_9BDF : 32'hBAD0_0002;
      @(negedge clk);
      exp_req = (c == 1) || (c == 2) || (c == 5) || (c == 6);
      checks++;
      if (mem_req !== exp_req) begin
        failures++;
        $display("FAIL rstmid_mem_req c=%0d got=%b exp=%b", c, mem_req, exp_req);
      end
      checks++;
      if (data_valid !== 1'b0 || inst_valid !== (c == 7)) begin
        failures++;
        $display("FAIL rstmid_valid c=%0d got d=%b i=%b exp d=0 i=%b", c, data_valid, inst_valid, (c == 7));
      end
      if (c == 3) begin
        checks++;
        if ({inst_rdata, data_rdata, mem_addr} !== 96'h0) begin
          failures++;
          $display("FAIL rstmid_cleared got=%h/%h/%h exp=0/0/0", inst_rdata, data_rdata, mem_addr);
        end
      end
      if (c == 5) begin
        checks++;
        if (mem_addr !== 32'h0000_0800) begin
          failures++;
          $display("FAIL rstmid_mem_addr got=%h exp=00000800", mem_addr);
        end
      end
      if (c == 7) begin
        checks++;
        if (inst_rdata !== 32'h1357_9BDF) begin
          failures++;
          $display("FAIL rstmid_rdata got=%h exp=13579bdf", inst_rdata);
        end
      end
      next_cycle();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    inst_req   = 1'b0;
    inst_addr  = 32'h0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    data_wstrb = 4'h0;
    mem_rdata  = 32'h0;
    mem_ack    = 1'b0;

    test_reset();
    test_fetch();
    test_priority();
    test_timeout();
    test_ack_at_limit();
    test_store();
    test_reset_midflight();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
